img2col_window_scheduler: RTL and testbench
===========================================

# img2col_window_scheduler

Sequences the img2col processing-unit control by walking a single-channel feature map in raster order and streaming 5x5 windows (stride 1) into it. For each window it fetches the needed pixel columns from feature-map SRAM into the 5-entry global buffer, and it signals a column-shift strobe and the per-row column index. It then hands the window downstream with a valid/ready handshake. It sits between the feature-map SRAM and the PU control/register-file path.

## Interface
- DATA_W, 16, pixel width
- ADDR_W, 12, SRAM word address width (covers 64x64 image)
- DIM_W, 7, width of image dimension inputs (legal values 5..64)
- clk  in  1  clock, rising edge
- nrst  in  1  reset; asynchronous, active-low
- start  in  1  begin a frame; sampled only in IDLE
- img_w  in  DIM_W  image width; latched on accepted start
- img_h  in  DIM_W  image height; latched on accepted start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse at end of frame
- mem_rd_en  out  1  SRAM read strobe
- mem_rd_addr  out  ADDR_W  SRAM read address = row*img_w + col
- mem_rd_data  in  DATA_W  SRAM data; valid exactly 1 cycle after mem_rd_en
- gbuf_wr_en  out  1  global buffer write enable
- gbuf_wr_addr  out  3  global buffer entry 0..4 (window row k)
- gbuf_wr_data  out  DATA_W  equals mem_rd_data
- col_done  out  1  one-cycle pulse: a full 5-pixel column is in the global buffer, PU shifts it in
- round  out  6  output column index c of the current window (0 = first window of a row)
- win_row  out  6  output row index r of the current window
- win_valid  out  1  window complete in PU, awaiting consumer
- win_ready  in  1  consumer accepts window

## Operation
- States: IDLE, LOAD, DRAIN, WIN, FIN.
- IDLE: all strobes low. On start=1: if img_w<5, img_h<5, img_w>64 or img_h>64, go to FIN (no SRAM reads). Otherwise latch dims, set r=0, c=0, cols_loaded=0, and go to LOAD.
- Column to load: col = c+cols_loaded if c==0, else c+4. Source rows r..r+4.
- LOAD: 5 cycles, k=0..4; mem_rd_en=1, mem_rd_addr=(r+k)*img_w+col. Each read is written one cycle later: gbuf_wr_en=1, gbuf_wr_addr=k, gbuf_wr_data=mem_rd_data. After k=4, go to DRAIN.
- DRAIN: 1 cycle. Last gbuf write (k=4); col_done=1; cols_loaded++.
  - If c==0 and cols_loaded<5 after increment, go to LOAD.
  - Otherwise go to WIN.
- WIN: win_valid=1; round=c and win_row=r held stable. No SRAM reads. On win_valid&&win_ready:
  - If c<img_w-5: c++ and go to LOAD.
  - Else if r<img_h-5: r++, c=0, cols_loaded=0, and go to LOAD.
  - Else go to FIN.
- FIN: done=1 for 1 cycle, busy=0, then go to IDLE.
- Address arithmetic is unsigned; (r+k)*img_w+col ≤ 4095 for legal dims. No wrap is possible.
- start while busy is ignored. img_w/img_h changes after start are ignored.
- Reset (any time, including mid-LOAD or WIN with unacknowledged window): state IDLE. All outputs 0 (busy, done, mem_rd_en, mem_rd_addr, gbuf_wr_*, col_done, round, win_row, win_valid). Counters cleared. No partial window is resumed.

## Timing
- All outputs registered. mem_rd_data has a fixed 1-cycle latency; gbuf writes trail reads by exactly 1 cycle.
- A column costs 6 cycles (5 LOAD + 1 DRAIN).
- start accepted at edge 0: LOAD cycles 1-5, DRAIN 6, ..., fifth column DRAIN at 30. win_valid asserts at cycle 31.
- Window handshake at cycle t with a non-row-start next window: LOAD t+1..t+5, DRAIN t+6, win_valid at t+7.
- Handshake at cycle t starting a new row: win_valid at t+31.
- Last handshake at t: done at t+1, busy low at t+1, IDLE at t+2. Invalid dims: done in the cycle after start.
- win_valid, once high, stays high with round/win_row stable until win_ready. win_ready while win_valid=0 is ignored.

## Test plan
- 5x5 image, win_ready=1: reads in order 0,5,10,15,20,1,6,...,24 (25 reads). Five col_done pulses. win_valid at cycle 31 with round=0, win_row=0. done at 32. Exactly one window.
- 6x5 image: second window reads only column 5 (addresses 5,11,17,23,29). round=1. win_valid 7 cycles after the first handshake. Two windows, then done.
- 6x6 image: windows (r,c) = (0,0),(0,1),(1,0),(1,1). The (1,0) window reloads 5 columns starting at address 6 (rows 1..5) with round=0. Four windows total.
- Backpressure: 6x5 image, hold win_ready=0 for 10 cycles on the first window. win_valid, round and win_row stay constant, with no mem_rd_en. After release, the second window follows at +7.
- Invalid dims: img_w=4 with start. done pulses next cycle; mem_rd_en and gbuf_wr_en never assert.
- Reset mid-frame: deassert nrst during the third LOAD cycle of a 6x6 frame. All outputs are 0 immediately. A new start re-fetches from address 0 with normal timing.

Source files
------------

// File: rtl/img2col_window_scheduler.sv
// Raster-order 5x5 window scheduler for the img2col PU. Fetches feature-map columns from SRAM
// into the 5-entry global buffer, then hands each completed window downstream.
module img2col_window_scheduler #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DIM_W  = 7
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              gbuf_wr_en,
  output logic [2:0]        gbuf_wr_addr,
  output logic [DATA_W-1:0] gbuf_wr_data,
  output logic              col_done,
  output logic [5:0]        round,
  output logic [5:0]        win_row,
  output logic              win_valid,
  input  logic              win_ready
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StDrain = 3'd2;
  localparam logic [2:0] StWin   = 3'd3;
  localparam logic [2:0] StFin   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [DIM_W-1:0]  w_q, w_d, h_q, h_d;
  logic [5:0]        r_q, r_d, c_q, c_d;
  logic [2:0]        cl_q, cl_d;
  logic [2:0]        k_q, k_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_en_q, wr_en_d;
  logic [2:0]        wr_addr_q, wr_addr_d;
  logic              col_done_q, col_done_d;
  logic [5:0]        round_q, round_d, win_row_q, win_row_d;
  logic              win_valid_q, win_valid_d;
  logic              dims_bad;
  logic [DIM_W-1:0]  row_sel, col_sel;

  assign dims_bad = (img_w < DIM_W'(5)) || (img_h < DIM_W'(5)) ||
                    (img_w > DIM_W'(64)) || (img_h > DIM_W'(64));

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    h_d         = h_q;
    r_d         = r_q;
    c_d         = c_q;
    cl_d        = cl_q;
    k_d         = k_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_en_d     = 1'b0;
    col_done_d  = 1'b0;
    round_d     = round_q;
    win_row_d   = win_row_q;
    win_valid_d = win_valid_q;
    // Buffer write trails the SRAM read by the fixed one-cycle read latency.
    wr_en_d     = rd_en_q;
    wr_addr_d   = k_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (dims_bad) begin
            state_d = StFin;
            done_d  = 1'b1;
          end else begin
            state_d = StLoad;
            w_d     = img_w;
            h_d     = img_h;
            r_d     = '0;
            c_d     = '0;
            cl_d    = '0;
            k_d     = '0;
            busy_d  = 1'b1;
            rd_en_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (k_q == 3'd4) begin
          state_d    = StDrain;
          col_done_d = 1'b1;
        end else begin
          k_d     = k_q + 3'd1;
          rd_en_d = 1'b1;
        end
      end
      StDrain: begin
        cl_d = cl_q + 3'd1;
        k_d  = '0;
        // Row-start windows need all five columns; later windows only the newest one.
        if (c_q == '0 && cl_q < 3'd4) begin
          state_d = StLoad;
          rd_en_d = 1'b1;
        end else begin
          state_d     = StWin;
          win_valid_d = 1'b1;
          round_d     = c_q;
          win_row_d   = r_q;
        end
      end
      StWin: begin
        if (win_ready) begin
          win_valid_d = 1'b0;
          k_d         = '0;
          if (DIM_W'(c_q) < w_q - DIM_W'(5)) begin
            c_d     = c_q + 6'd1;
            state_d = StLoad;
            rd_en_d = 1'b1;
          end else if (DIM_W'(r_q) < h_q - DIM_W'(5)) begin
            r_d     = r_q + 6'd1;
            c_d     = '0;
            cl_d    = '0;
            state_d = StLoad;
            rd_en_d = 1'b1;
          end else begin
            state_d = StFin;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    row_sel   = DIM_W'(r_d) + DIM_W'(k_d);
    col_sel   = (c_d == '0) ? DIM_W'(cl_d) : DIM_W'(c_d) + DIM_W'(4);
    rd_addr_d = rd_en_d ? ADDR_W'(row_sel) * ADDR_W'(w_d) + ADDR_W'(col_sel) : '0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= StIdle;
      w_q         <= '0;
      h_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      cl_q        <= '0;
      k_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      col_done_q  <= 1'b0;
      round_q     <= '0;
      win_row_q   <= '0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      h_q         <= h_d;
      r_q         <= r_d;
      c_q         <= c_d;
      cl_q        <= cl_d;
      k_q         <= k_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      col_done_q  <= col_done_d;
      round_q     <= round_d;
      win_row_q   <= win_row_d;
      win_valid_q <= win_valid_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign mem_rd_en    = rd_en_q;
  assign mem_rd_addr  = rd_addr_q;
  assign gbuf_wr_en   = wr_en_q;
  assign gbuf_wr_addr = wr_addr_q;
  // SRAM data arrives in the write cycle itself; masked so idle/reset shows zero.
  assign gbuf_wr_data = wr_en_q ? mem_rd_data : '0;
  assign col_done     = col_done_q;
  assign round        = round_q;
  assign win_row      = win_row_q;
  assign win_valid    = win_valid_q;

endmodule

// File: tb/tb_img2col_window_scheduler.sv
// Self-checking bench: a frame-level model predicts read addresses, buffer writes, window order
// and handshake latencies; directed frames add hand-computed literal expectations.
module tb_img2col_window_scheduler;

  logic        clk = 1'b0;
  logic        nrst, start, win_ready;
  logic [6:0]  img_w, img_h;
  logic        busy, done, mem_rd_en, gbuf_wr_en, col_done, win_valid;
  logic [11:0] mem_rd_addr;
  logic [15:0] mem_rd_data = '0;
  logic [15:0] gbuf_wr_data;
  logic [2:0]  gbuf_wr_addr;
  logic [5:0]  round, win_row;

  img2col_window_scheduler dut (
    .clk         (clk),
    .nrst        (nrst),
    .start       (start),
    .img_w       (img_w),
    .img_h       (img_h),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .gbuf_wr_en  (gbuf_wr_en),
    .gbuf_wr_addr(gbuf_wr_addr),
    .gbuf_wr_data(gbuf_wr_data),
    .col_done    (col_done),
    .round       (round),
    .win_row     (win_row),
    .win_valid   (win_valid),
    .win_ready   (win_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] sram_word(input int a);
    return 16'hA000 ^ 16'(a * 37);
  endfunction

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= sram_word(int'(mem_rd_addr));

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {int r; int c; int lat;} win_t;

  int          exp_addr[$];
  win_t        exp_win[$];
  int          rd_log[$];
  bit          m_active = 0;
  bit          wr_pend = 0;
  bit          wv_prev = 0;
  int          wr_k = 0;
  logic [15:0] wr_data = '0;
  int          rd_idx = 0;
  int          t_ev = 0;
  int          done_at = -1;
  int          acc_cyc = 0;
  int          win_first_cyc = 0;
  int          win_count = 0;
  int          col_done_cnt = 0;

  function automatic int log_at(input int i);
    return (rd_log.size() > i) ? rd_log[i] : -1;
  endfunction

  // Model + compare, sampled on the falling edge.
  always @(negedge clk) begin
    if (!nrst) begin
      m_active = 0;
      exp_addr.delete();
      exp_win.delete();
      wr_pend  = 0;
      wv_prev  = 0;
      done_at  = -1;
    end else begin
      check("done", int'(done), int'(cyc == done_at));
      check("col_done", int'(col_done), int'(wr_pend && wr_k == 4));
      check("gbuf_wr_en", int'(gbuf_wr_en), int'(wr_pend));
      if (wr_pend && gbuf_wr_en) begin
        check("gbuf_wr_addr", int'(gbuf_wr_addr), wr_k);
        check("gbuf_wr_data", int'(gbuf_wr_data), int'(wr_data));
      end
      if (col_done) col_done_cnt++;
      wr_pend = 0;
      if (!m_active) begin
        check("idle_busy", int'(busy), 0);
        check("idle_rd", int'(mem_rd_en), 0);
        check("idle_win", int'(win_valid), 0);
      end else begin
        check("busy", int'(busy), int'(cyc != done_at));
        if (mem_rd_en) begin
          check("rd_during_win", int'(win_valid), 0);
          rd_log.push_back(int'(mem_rd_addr));
          if (exp_addr.size() == 0) begin
            check("rd_extra", int'(mem_rd_en), 0);
          end else begin
            check("rd_addr", int'(mem_rd_addr), exp_addr[0]);
            wr_pend = 1;
            wr_k    = rd_idx % 5;
            wr_data = sram_word(exp_addr[0]);
            void'(exp_addr.pop_front());
            rd_idx++;
          end
        end
        if (win_valid) begin
          if (exp_win.size() == 0) begin
            check("win_extra", int'(win_valid), 0);
          end else begin
            if (!wv_prev) begin
              check("win_latency", cyc - t_ev, exp_win[0].lat);
              if (win_count == 0) win_first_cyc = cyc;
            end
            check("round", int'(round), exp_win[0].c);
            check("win_row", int'(win_row), exp_win[0].r);
            if (win_ready) begin
              void'(exp_win.pop_front());
              win_count++;
              t_ev = cyc;
              if (exp_win.size() == 0) begin
                done_at = cyc + 1;
                check("reads_left", exp_addr.size(), 0);
              end
            end
          end
          wv_prev = !win_ready;
        end else begin
          if (wv_prev) check("win_valid_hold", int'(win_valid), 1);
          wv_prev = 0;
        end
        if (cyc == done_at) m_active = 0;
      end
      if (!m_active && start && cyc != done_at) begin
        acc_cyc = cyc;
        rd_log.delete();
        win_count = 0;
        col_done_cnt = 0;
        if (img_w < 5 || img_h < 5 || img_w > 64 || img_h > 64) begin
          done_at = cyc + 1;
        end else begin
          m_active = 1;
          t_ev     = cyc;
          rd_idx   = 0;
          wv_prev  = 0;
          done_at  = -1;
          for (int r = 0; r <= int'(img_h) - 5; r++)
            for (int c = 0; c <= int'(img_w) - 5; c++) begin
              exp_win.push_back(win_t'{r, c, (c == 0) ? 31 : 7});
              for (int j = (c == 0) ? 0 : 4; j <= 4; j++)
                for (int k = 0; k < 5; k++) exp_addr.push_back((r + k) * int'(img_w) + c + j);
            end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, int'({busy, done, mem_rd_en, gbuf_wr_en, col_done, win_valid}), 0);
    check({tag, "_addr"}, int'(mem_rd_addr), 0);
    check({tag, "_gbuf"}, int'({gbuf_wr_addr, gbuf_wr_data}), 0);
    check({tag, "_idx"}, int'({round, win_row}), 0);
  endtask

  task automatic run_frame(input int w, input int h, input int hold, input bit glitch);
    img_w     = 7'(w);
    img_h     = 7'(h);
    win_ready = (hold == 0);
    start     = 1'b1;
    tick();
    start = 1'b0;
    if (glitch) begin
      repeat (8) tick();
      img_w = 7'd5;
      img_h = 7'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    if (hold > 0) begin
      for (int i = 0; i < 100 && !win_valid; i++) tick();
      check("bp_win_seen", int'(win_valid), 1);
      repeat (hold) tick();
      win_ready = 1'b1;
    end
    for (int i = 0; i < 5000 && !done; i++) tick();
    check("frame_done_seen", int'(done), 1);
    tick();
  endtask

  int lit5 [6] = '{0, 5, 10, 15, 20, 1};
  int lit65[5] = '{5, 11, 17, 23, 29};

  initial begin
    nrst = 1'b0; start = 1'b0; win_ready = 1'b1; img_w = '0; img_h = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    nrst = 1'b1;
    tick();

    run_frame(5, 5, 0, 1'b0);
    for (int i = 0; i < 6; i++) check("r5x5_rd", log_at(i), lit5[i]);
    check("r5x5_last_rd", log_at(24), 24);
    check("r5x5_nreads", rd_log.size(), 25);
    check("r5x5_col_done", col_done_cnt, 5);
    check("r5x5_win_at", win_first_cyc - acc_cyc, 31);
    check("r5x5_done_at", done_at - acc_cyc, 32);
    check("r5x5_nwin", win_count, 1);

    run_frame(6, 5, 0, 1'b1);
    for (int i = 0; i < 5; i++) check("r6x5_col5", log_at(25 + i), lit65[i]);
    check("r6x5_nreads", rd_log.size(), 30);
    check("r6x5_nwin", win_count, 2);
    check("r6x5_done_at", done_at - acc_cyc, 39);

    run_frame(6, 6, 0, 1'b0);
    check("r6x6_reload0", log_at(30), 6);
    check("r6x6_reload4", log_at(34), 30);
    check("r6x6_last_rd", log_at(59), 35);
    check("r6x6_nreads", rd_log.size(), 60);
    check("r6x6_nwin", win_count, 4);

    run_frame(6, 5, 10, 1'b0);
    check("bp_nwin", win_count, 2);
    check("bp_done_at", done_at - acc_cyc, 49);

    run_frame(4, 6, 0, 1'b0);
    check("bad_w_done_at", done_at - acc_cyc, 1);
    check("bad_w_nreads", rd_log.size(), 0);
    run_frame(6, 65, 0, 1'b0);
    check("bad_h_done_at", done_at - acc_cyc, 1);

    // Reset in the third LOAD cycle of a 6x6 frame.
    img_w = 7'd6; img_h = 7'd6; win_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre_rst_rd", int'(mem_rd_en), 1);
    #2 nrst = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) tick();
    nrst = 1'b1;
    tick();
    run_frame(6, 6, 0, 1'b0);
    check("post_rst_rd0", log_at(0), 0);
    check("post_rst_rd1", log_at(1), 6);
    check("post_rst_win_at", win_first_cyc - acc_cyc, 31);
    check("post_rst_nwin", win_count, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
